cpu2: RTL
=========

CPU2 -- requirements
Module: cpu2

Interface
REQ-001 DATA_W, 8, data word and register width; legal range 8..32.
REQ-002 ADDR_W, 16, address width; legal range 8..32.
REQ-003 RESET_PC, 'h2000, first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 addr  out  ADDR_W  bus address.
REQ-007 data_in  in  DATA_W  read data, sampled when r=1 and ready=1.
REQ-008 data_out  out  DATA_W  write data, valid while w=1.
REQ-009 r  out  1  read strobe.
REQ-010 w  out  1  write strobe.
REQ-011 ready  in  1  bus acknowledge; a transfer completes on the edge where strobe=1 and ready=1.
REQ-012 halt  out  1  core stopped.
REQ-013 flags  out  4  {N,V,Z,C}.

Function
REQ-014 State: 16 registers R0..R15, each DATA_W wide; pc is ADDR_W wide and wraps from all-ones to 0; ERk = {R(9+2k),R(8+2k)} for k=0..3, truncated or zero-extended to ADDR_W.
REQ-015 FSM states and transitions:
- F0 -> F1: fetch word0.
- F1 -> EX: fetch word1.
- EX -> F0, or EX -> MEM for LD/ST, or EX -> HLT for HLT.
- MEM -> F0.
- HLT: absorbing until reset.
REQ-016 In F0 and F1, r=1 and addr=pc; on ready the word is latched and pc increments; while ready=0, addr, r and state hold.
REQ-017 Only word0[7:0] is decoded; DATA_W>8 upper bits are ignored.
REQ-018 word0[3:0] ∈ {0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC, 0100 AND, 0110 OR, 1000 XOR, 1010 MOV, 1100 CMP}: immediate op, rd=word0[7:4], src=word1.
REQ-019 word0[3:0]=0111: register op, op=word0[7:4] (same codes), rs=word1[7:4], rd=word1[3:0].
REQ-020 word0[3:0]=0101: branch, cond=word0[7:4]:
- 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 V.
- If taken, pc += sign-extended word1, relative to pc after the word1 fetch.
- Any other cond is never taken.
REQ-021 word0[3:0]=1001: LD, Rd=word0[7:4] <- mem[ER(word1[1:0])]; word0[3:0]=1011: ST, mem[ER(word1[1:0])] <- Rd.
REQ-022 word0[4:0]=11111: op=word0[7:5]; 000 CLC, 001 CLZ, 010 CLO, 011 CLN, 110 NOP, 111 HLT; all other codes act as NOP.
REQ-023 Every unlisted word0 encoding executes as NOP; both words are still fetched.
REQ-024 Arithmetic is DATA_W+1 wide with C = bit DATA_W; SUB, SBC and CMP set C as borrow; ADC adds C; SBC subtracts C.
REQ-025 Overflow is two's-complement; N = result MSB; Z = (result==0).
REQ-026 Flag updates:
- ADD, ADC, SUB, SBC, CMP update all four flags.
- AND, OR, XOR update Z and N, clear V, leave C unchanged.
- MOV, LD and ST leave flags unchanged.
REQ-027 CMP writes flags only; Rd is unchanged.
REQ-028 When rd=rs, the operand is the pre-execution value.
REQ-029 MEM state: LD drives r=1 and addr=ER; ST drives w=1, addr=ER and data_out=Rd; the state holds until ready; LD writes Rd on the ready edge.
REQ-030 r and w are never both 1; both are 0 in EX and HLT.
REQ-031 Latency with ready tied 1: 3 cycles per instruction, 4 for LD/ST.
REQ-032 In HLT: halt=1, strobes are 0, no further fetch.

Reset
REQ-033 While reset=1: state=F0, pc=RESET_PC, R0..R15=0, flags=0, halt=0, r=w=0, data_out=0, addr=RESET_PC.
REQ-034 Reset asserted mid-transfer clears r and w immediately, without waiting for a clock edge.
REQ-035 The first fetch strobe (r=1) appears in the first cycle after reset deasserts.

Structure
REQ-036 A shared package cpu2_pkg holds:
- State enum.
- Math, other and condition opcode constants.
- Group encodings.
- Flag bit indices.
REQ-037 One sub-module, cpu2_alu, is combinational and takes op, a, b and carry-in, returning result, {N,V,Z,C} and a write-enable.

Verification
REQ-038 Test cases (DATA_W=8, ADDR_W=16; ready=1 unless stated):
- Reset, then program MOV R1,#0xFF; ADD R1,#0x01 -> R1=0x00, C=1, Z=1, first addr=0x2000, 6 cycles total.
- MOV R2,#0x7F; ADD R2,#1 -> R2=0x80, V=1, N=1, C=0; then CMP R2,#0x80 -> Z=1, R2=0x80 unchanged.
- MOV R8,#0x34; MOV R9,#0x12; ST R3 via ER0 -> w=1, addr=0x1234; with ready held 0 for 3 cycles, addr, w and data_out are held stable.
- BNZ with offset 0xFE after a SUB that leaves Z=0 -> next fetch addr = pc-2; with Z=1 -> fall through.
- HLT -> halt=1 and no strobes for 20 cycles; asserting reset mid-F1 with ready=0 -> r drops asynchronously and fetch restarts at 0x2000.

Source files
------------

// File: rtl/cpu2_pkg.sv
// cpu2_pkg -- shared definitions for the cpu2 core.
//   state_t      : fetch/execute/memory FSM states
//   OP_*         : math/logic opcodes, shared by immediate and register forms
//   GRP_*        : word0 group encodings (register op, branch, load, store, other)
//   OTH_*        : opcodes of the "other" group selected by word0[7:5]
//   CND_*        : branch condition codes
//   FLAG_*       : bit positions inside the {N,V,Z,C} flag vector
package cpu2_pkg;

  typedef enum logic [2:0] {
    ST_F0  = 3'd0,   // fetch word0
    ST_F1  = 3'd1,   // fetch word1
    ST_EX  = 3'd2,   // decode and execute
    ST_MEM = 3'd3,   // LD/ST data transfer
    ST_HLT = 3'd4    // stopped until reset
  } state_t;

  // Math/logic opcodes.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hC;

  // Group encodings in word0.
  localparam logic [3:0] GRP_REG    = 4'h7;
  localparam logic [3:0] GRP_BRANCH = 4'h5;
  localparam logic [3:0] GRP_LD     = 4'h9;
  localparam logic [3:0] GRP_ST     = 4'hB;
  localparam logic [4:0] GRP_OTHER  = 5'h1F;

  // "Other" group opcodes (word0[7:5]).
  localparam logic [2:0] OTH_CLC = 3'd0;
  localparam logic [2:0] OTH_CLZ = 3'd1;
  localparam logic [2:0] OTH_CLO = 3'd2;
  localparam logic [2:0] OTH_CLN = 3'd3;
  localparam logic [2:0] OTH_NOP = 3'd6;
  localparam logic [2:0] OTH_HLT = 3'd7;

  // Branch conditions (word0[7:4]).
  localparam logic [3:0] CND_AL = 4'd0;
  localparam logic [3:0] CND_Z  = 4'd1;
  localparam logic [3:0] CND_NZ = 4'd2;
  localparam logic [3:0] CND_C  = 4'd3;
  localparam logic [3:0] CND_NC = 4'd4;
  localparam logic [3:0] CND_N  = 4'd5;
  localparam logic [3:0] CND_V  = 4'd6;

  // Flag vector layout {N,V,Z,C}.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND,
      OP_OR, OP_XOR, OP_MOV, OP_CMP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Unlisted condition codes are never taken.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    case (cond)
      CND_AL:  return 1'b1;
      CND_Z:   return f[FLAG_Z];
      CND_NZ:  return !f[FLAG_Z];
      CND_C:   return f[FLAG_C];
      CND_NC:  return !f[FLAG_C];
      CND_N:   return f[FLAG_N];
      CND_V:   return f[FLAG_V];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu2_alu.sv
// cpu2_alu -- combinational ALU for cpu2.
//   op       : math/logic opcode (OP_*)
//   a, b     : destination operand and source operand
//   cin      : current carry flag (ADC/SBC input, passed through by logic ops)
//   result   : value to write to Rd
//   flags    : {N,V,Z,C} produced by the operation
//   flags_we : flags must be updated
//   rd_we    : Rd must be written (clear for CMP and unlisted opcodes)
module cpu2_alu
  import cpu2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              flags_we,
  output logic              rd_we
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;
  logic            is_arith;
  logic            is_sub;
  logic            v;

  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    wide     = '0;
    is_arith = 1'b0;
    is_sub   = 1'b0;
    result   = '0;
    flags_we = 1'b0;
    rd_we    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        is_arith = 1'b1; rd_we = 1'b1;
      end
      OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        is_arith = 1'b1; rd_we = 1'b1;
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        is_arith = 1'b1; is_sub = 1'b1; rd_we = 1'b1;
      end
      OP_SBC: begin
        wide = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
        is_arith = 1'b1; is_sub = 1'b1; rd_we = 1'b1;
      end
      OP_CMP: begin
        wide = {1'b0, a} - {1'b0, b};
        is_arith = 1'b1; is_sub = 1'b1;
      end
      OP_AND: begin result = a & b; flags_we = 1'b1; rd_we = 1'b1; end
      OP_OR:  begin result = a | b; flags_we = 1'b1; rd_we = 1'b1; end
      OP_XOR: begin result = a ^ b; flags_we = 1'b1; rd_we = 1'b1; end
      OP_MOV: begin result = b;     rd_we = 1'b1;                   end
      default: ;
    endcase

    if (is_arith) begin
      result   = wide[DATA_W-1:0];
      flags_we = 1'b1;
    end

    // Two's-complement overflow: add overflows when the operands share a sign
    // the result lacks; subtract when the operand signs differ and the result
    // sign departs from a. Both hold with a carry/borrow-in folded in.
    if (is_sub) v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
    else        v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);

    flags         = '0;
    flags[FLAG_N] = result[MSB];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_V] = is_arith && v;
    // C is the borrow for subtract forms; logic ops keep the old carry.
    flags[FLAG_C] = is_arith ? wide[DATA_W] : cin;
  end

endmodule

// File: rtl/cpu2.sv
// cpu2 -- small two-word-instruction accumulator-free register CPU.
//   clk      : sole clock, rising edge
//   reset    : asynchronous, active-high
//   addr     : bus address (pc while fetching, ER pair during LD/ST)
//   data_in  : read data, taken when r=1 and ready=1
//   data_out : store data, valid while w=1
//   r, w     : read / write strobes, never both high
//   ready    : bus acknowledge; a transfer completes on an edge with strobe&ready
//   halt     : core stopped by HLT
//   flags    : {N,V,Z,C}
module cpu2
  import cpu2_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 'h2000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              r,
  output logic              w,
  input  logic              ready,
  output logic              halt,
  output logic [3:0]        flags
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] word0, word1;
  logic [DATA_W-1:0] regs [16];
  logic [3:0]        flag_q;

  // Decode: only word0[7:0] is meaningful.
  logic [3:0] grp, hi;
  logic [2:0] oth_op;
  logic       is_other, is_imm, is_reg, is_br, is_ld, is_st, is_hlt;

  assign grp      = word0[3:0];
  assign hi       = word0[7:4];
  assign oth_op   = word0[7:5];
  assign is_other = (word0[4:0] == GRP_OTHER);
  assign is_imm   = !is_other && is_alu_op(grp);
  assign is_reg   = (grp == GRP_REG);
  assign is_br    = (grp == GRP_BRANCH);
  assign is_ld    = (grp == GRP_LD);
  assign is_st    = (grp == GRP_ST);
  assign is_hlt   = is_other && (oth_op == OTH_HLT);

  // ALU operand selection. Register form: op in word0[7:4], rs/rd in word1.
  logic [3:0]        alu_op, rd_idx, rs_idx;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]        alu_flags;
  logic              alu_flags_we, alu_rd_we, alu_en;

  assign alu_op = is_reg ? hi : grp;
  assign rd_idx = is_reg ? word1[3:0] : hi;
  assign rs_idx = word1[7:4];
  assign alu_a  = regs[rd_idx];
  assign alu_b  = is_reg ? regs[rs_idx] : word1;
  assign alu_en = is_imm || is_reg;

  cpu2_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (alu_op),
    .a        (alu_a),
    .b        (alu_b),
    .cin      (flag_q[FLAG_C]),
    .result   (alu_result),
    .flags    (alu_flags),
    .flags_we (alu_flags_we),
    .rd_we    (alu_rd_we)
  );

  // ERk = {R(9+2k), R(8+2k)}, zero-extended or truncated to the address width.
  logic [3:0]        er_lo_idx, er_hi_idx;
  logic [ADDR_W-1:0] ea;
  assign er_lo_idx = {1'b1, word1[1:0], 1'b0};
  assign er_hi_idx = {1'b1, word1[1:0], 1'b1};
  assign ea        = ADDR_W'({regs[er_hi_idx], regs[er_lo_idx]});

  // Branch displacement is word1 sign-extended (or truncated) to pc width.
  logic [ADDR_W-1:0] br_off;
  logic              br_taken;
  assign br_off   = ADDR_W'($signed(word1));
  assign br_taken = cond_true(hi, flag_q);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_F0;
    else       state <= next_state;
  end

  // Next state and bus outputs.
  always_comb begin
    next_state = state;
    addr       = pc;
    r          = 1'b0;
    w          = 1'b0;
    data_out   = '0;
    case (state)
      ST_F0: begin
        r = 1'b1;
        if (ready) next_state = ST_F1;
      end
      ST_F1: begin
        r = 1'b1;
        if (ready) next_state = ST_EX;
      end
      ST_EX: begin
        if (is_ld || is_st) next_state = ST_MEM;
        else if (is_hlt)    next_state = ST_HLT;
        else                next_state = ST_F0;
      end
      ST_MEM: begin
        addr = ea;
        if (is_ld) begin
          r = 1'b1;
        end else begin
          w        = 1'b1;
          data_out = regs[hi];
        end
        if (ready) next_state = ST_F0;
      end
      ST_HLT:  next_state = ST_HLT;
      default: next_state = ST_F0;
    endcase
    // Strobes fall the instant reset rises, even in the middle of a transfer.
    if (reset) begin
      r = 1'b0;
      w = 1'b0;
    end
  end

  // Datapath: pc, instruction words, register file and flags.
  // NOTE: the register file is built from flops rather than a RAM, which is
  // what allows it to be cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= PC_INIT;
      word0  <= '0;
      word1  <= '0;
      flag_q <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_F0: if (ready) begin
          word0 <= data_in;
          pc    <= pc + ADDR_W'(1);
        end
        ST_F1: if (ready) begin
          word1 <= data_in;
          pc    <= pc + ADDR_W'(1);
        end
        ST_EX: begin
          if (alu_en && alu_rd_we)    regs[rd_idx] <= alu_result;
          if (alu_en && alu_flags_we) flag_q       <= alu_flags;
          // pc already points past word1, so the offset is relative to it.
          if (is_br && br_taken)      pc           <= pc + br_off;
          if (is_other) begin
            case (oth_op)
              OTH_CLC: flag_q[FLAG_C] <= 1'b0;
              OTH_CLZ: flag_q[FLAG_Z] <= 1'b0;
              OTH_CLO: flag_q[FLAG_V] <= 1'b0;
              OTH_CLN: flag_q[FLAG_N] <= 1'b0;
              default: ;
            endcase
          end
        end
        ST_MEM: if (ready && is_ld) regs[hi] <= data_in;
        default: ;
      endcase
    end
  end

  assign halt  = (state == ST_HLT);
  assign flags = flag_q;

endmodule
